// File: rtl/unidade_busca.sv
// unidade_busca: instruction-fetch unit (PC register, memory request/ack, decode valid/stall handshake).
// Optional CONTADOR_BUSCAS_EN adds the num_buscas fetch counter output.
module unidade_busca #(
    parameter int                 LARGURA    = 32,
    parameter logic [LARGURA-1:0] PC_INICIAL = '0
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               habilita,
    input  logic               desvio,
    input  logic [LARGURA-1:0] alvo_desvio,
    input  logic               parada,
    output logic               mem_req,
    output logic [LARGURA-1:0] mem_endereco,
    input  logic               mem_pronto,
    input  logic [LARGURA-1:0] mem_dado,
    output logic [LARGURA-1:0] instrucao,
    output logic               instr_valida,
    output logic [LARGURA-1:0] pc_atual,
    output logic [LARGURA-1:0] pc_mais4
`ifdef CONTADOR_BUSCAS_EN
   ,output logic [31:0]        num_buscas
`endif
);
    typedef enum logic [1:0] {OCIOSO, REQUISITA, ENTREGA} estado_t;
    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] pc_q, pc_d, instr_q, instr_d;
    logic               valida_q, valida_d;
    assign mem_req      = (estado_q == REQUISITA);
    assign mem_endereco = pc_q;
    assign pc_atual     = pc_q;
    assign pc_mais4     = pc_q + LARGURA'(4);
    assign instrucao    = instr_q;
    assign instr_valida = valida_q;
    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valida_d = valida_q;
        // redirect wins over everything, including an ack in the same cycle
        if (desvio) begin
            pc_d     = alvo_desvio & ~LARGURA'(3);
            valida_d = 1'b0;
            estado_d = habilita ? REQUISITA : OCIOSO;
        end else begin
            case (estado_q)
                OCIOSO: if (habilita) estado_d = REQUISITA;
                REQUISITA: if (mem_pronto) begin
                    instr_d  = mem_dado;
                    valida_d = 1'b1;
                    pc_d     = pc_mais4;
                    estado_d = ENTREGA;
                end
                ENTREGA: if (!parada) begin
                    valida_d = 1'b0;
                    estado_d = habilita ? REQUISITA : OCIOSO;
                end
                default: estado_d = OCIOSO;
            endcase
        end
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            estado_q <= OCIOSO;
            pc_q     <= PC_INICIAL;
            instr_q  <= '0;
            valida_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valida_q <= valida_d;
        end
    end
`ifdef CONTADOR_BUSCAS_EN
    logic [31:0] num_q;
    assign num_buscas = num_q;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) num_q <= '0;
        else if (valida_d && !valida_q) num_q <= num_q + 32'd1;
    end
`endif
endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: directed bench with an expected-instruction scoreboard for unidade_busca.
module tb_unidade_busca;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        habilita = 1'b0, desvio = 1'b0, parada = 1'b0, mem_pronto = 1'b0;
    logic [31:0] alvo_desvio = '0;
    logic        mem_req, instr_valida;
    logic [31:0] mem_endereco, mem_dado, instrucao, pc_atual, pc_mais4;
    logic        hab_w = 1'b0;
    logic        req_w, val_w;
    logic [31:0] end_w, dado_w, instr_w, pc_w, p4_w;
`ifdef CONTADOR_BUSCAS_EN
    logic [31:0] num_buscas, num_w;
`endif
    int          n_tests = 0, n_fail = 0;
    logic [31:0] exp_q[$];
    logic        prev_v = 1'b0;

    assign mem_dado = mem_endereco;
    assign dado_w   = end_w;

    unidade_busca #(.LARGURA(32), .PC_INICIAL(32'h0)) dut (
        .clock(clock), .resetn(resetn), .habilita(habilita), .desvio(desvio),
        .alvo_desvio(alvo_desvio), .parada(parada), .mem_req(mem_req),
        .mem_endereco(mem_endereco), .mem_pronto(mem_pronto), .mem_dado(mem_dado),
        .instrucao(instrucao), .instr_valida(instr_valida), .pc_atual(pc_atual),
        .pc_mais4(pc_mais4)
`ifdef CONTADOR_BUSCAS_EN
       ,.num_buscas(num_buscas)
`endif
    );

    unidade_busca #(.LARGURA(32), .PC_INICIAL(32'hFFFF_FFFC)) dut_w (
        .clock(clock), .resetn(resetn), .habilita(hab_w), .desvio(1'b0),
        .alvo_desvio(32'h0), .parada(1'b0), .mem_req(req_w),
        .mem_endereco(end_w), .mem_pronto(1'b1), .mem_dado(dado_w),
        .instrucao(instr_w), .instr_valida(val_w), .pc_atual(pc_w),
        .pc_mais4(p4_w)
`ifdef CONTADOR_BUSCAS_EN
       ,.num_buscas(num_w)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock edge, then scoreboard any newly delivered instruction
    task automatic tick();
        @(posedge clock);
        #1;
        if (instr_valida && !prev_v) begin
            if (exp_q.size() == 0) check("unexpected_delivery", instrucao, 32'hDEAD_BEEF);
            else check("scoreboard_instr", instrucao, exp_q.pop_front());
        end
        prev_v = instr_valida;
    endtask

    initial begin
        tick();
        tick();
        check("rst_pc", pc_atual, 32'h0);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_valida", {31'b0, instr_valida}, 32'h0);
        check("rst_instr", instrucao, 32'h0);
        check("rst_wrap_pc", pc_w, 32'hFFFF_FFFC);
        check("rst_wrap_pc4", p4_w, 32'h0);
        resetn = 1'b1; habilita = 1'b1; mem_pronto = 1'b1; hab_w = 1'b1;
        tick();
        check("req_rise", {31'b0, mem_req}, 32'h1);
        check("req_addr0", mem_endereco, 32'h0);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(32'(k * 4));
            tick();
            check("seq_valida", {31'b0, instr_valida}, 32'h1);
            check("seq_pc", pc_atual, 32'((k + 1) * 4));
            if (k == 0) begin
                check("wrap_pc", pc_w, 32'h0);
                hab_w = 1'b0;
            end
            if (k == 3) break;
            tick();
            check("seq_gap", {31'b0, instr_valida}, 32'h0);
        end
`ifdef CONTADOR_BUSCAS_EN
        check("num_buscas", num_buscas, 32'd4);
`endif
        // memory wait: redirect to 0x4, then three cycles without ack
        mem_pronto = 1'b0; desvio = 1'b1; alvo_desvio = 32'h4;
        tick();
        desvio = 1'b0;
        check("wait_addr0", mem_endereco, 32'h4);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wait_addr", mem_endereco, 32'h4);
            check("wait_req", {31'b0, mem_req}, 32'h1);
            check("wait_valida", {31'b0, instr_valida}, 32'h0);
        end
        mem_pronto = 1'b1; exp_q.push_back(32'h4);
        tick();
        check("wait_ack_valida", {31'b0, instr_valida}, 32'h1);
        check("wait_pc", pc_atual, 32'h8);
        parada = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("stall_valida", {31'b0, instr_valida}, 32'h1);
            check("stall_instr", instrucao, 32'h4);
            check("stall_req", {31'b0, mem_req}, 32'h0);
        end
        parada = 1'b0;
        tick();
        check("unstall_valida", {31'b0, instr_valida}, 32'h0);
        check("unstall_req", {31'b0, mem_req}, 32'h1);
        check("unstall_addr", mem_endereco, 32'h8);
        desvio = 1'b1; alvo_desvio = 32'h103;
        tick();
        desvio = 1'b0;
        check("redir_discard", {31'b0, instr_valida}, 32'h0);
        check("redir_addr", mem_endereco, 32'h100);
        check("redir_req", {31'b0, mem_req}, 32'h1);
        exp_q.push_back(32'h100);
        tick();
        check("redir_fetch_pc", pc_atual, 32'h104);
        habilita = 1'b0;
        tick();
        check("park_req", {31'b0, mem_req}, 32'h0);
        tick();
        check("late_ack_req", {31'b0, mem_req}, 32'h0);
        check("late_ack_valida", {31'b0, instr_valida}, 32'h0);
        check("late_ack_pc", pc_atual, 32'h104);
        habilita = 1'b1;
        tick();
        habilita = 1'b0; mem_pronto = 1'b0;
        tick();
        check("hab_drop_req", {31'b0, mem_req}, 32'h1);
        mem_pronto = 1'b1; exp_q.push_back(32'h104);
        tick();
        check("hab_drop_valida", {31'b0, instr_valida}, 32'h1);
        tick();
        check("hab_drop_park", {31'b0, mem_req}, 32'h0);
        check("hab_drop_clear", {31'b0, instr_valida}, 32'h0);
        habilita = 1'b1;
        tick();
        check("pre_rst_req", {31'b0, mem_req}, 32'h1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_req", {31'b0, mem_req}, 32'h0);
        check("async_rst_pc", mem_endereco, 32'h0);
        check("async_rst_valida", {31'b0, instr_valida}, 32'h0);
`ifdef CONTADOR_BUSCAS_EN
        check("async_rst_num", num_buscas, 32'd0);
`endif
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
